// File: rtl/mux_scan_sampler_pkg.sv
// Shared types and constants for the mux scan sampler: FSM state encoding,
// default frame geometry and the select-bus width.
package mux_scan_sampler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    localparam int NUM_CH_DEF = 6;
    localparam int DWELL_DEF  = 4;
    localparam int SEL_W      = 3;

endpackage

// File: rtl/dwell_timer.sv
// Settle-period counter: counts 0..DWELL-1 while enabled and holds at the
// terminal count until cleared, so it never wraps on its own.
module dwell_timer
    import mux_scan_sampler_pkg::*;
#(
    parameter int DWELL = DWELL_DEF
) (
    input  logic clock,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is always updated with non-blocking assignments
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !done) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == LAST);

endmodule

// File: rtl/mux_scan_sampler.sv
// Steps the channel-mux select through every channel, waits out the settle
// period, samples the mux output and publishes each complete frame.
module mux_scan_sampler
    import mux_scan_sampler_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DWELL  = DWELL_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              cont,
    input  logic              mux_in,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] sample,
    output logic              valid,
    output logic              busy
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [SEL_W-1:0]  ch;
    logic [NUM_CH-1:0] shadow;
    logic [NUM_CH-1:0] frame_word;
    logic              dwell_done;
    logic              last_ch;

    assign last_ch = (ch == LAST_CH);

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clock  (clock),
        .resetn (resetn),
        .clr    (state != SETTLE),
        .en     (state == SETTLE),
        .done   (dwell_done)
    );

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (dwell_done) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = (last_ch && !cont) ? IDLE : SETTLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The final channel's bit comes straight from mux_in so the published
    // word is complete on the same edge that captures it.
    always_comb begin
        frame_word = shadow;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch == SEL_W'(i)) frame_word[i] = mux_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: shadow is a handful of flops, not a RAM, so it is reset along
    // with the rest; a reset mid-frame leaves no stale channel bits behind.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ch     <= '0;
            shadow <= '0;
            sample <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) ch <= '0;
                end
                SAMPLE: begin
                    shadow <= frame_word;
                    if (last_ch) begin
                        sample <= frame_word;
                        valid  <= 1'b1;
                        ch     <= '0;
                    end else begin
                        ch <= ch + SEL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sel  = (state == IDLE) ? '0 : ch;
    assign busy = (state != IDLE);

endmodule
